imem_uart_loader: RTL and testbench

//  Boot loader that writes the instruction memory from a UART byte stream

---
 rtl/imem_uart_loader_if.sv | 21 ++
 rtl/imem_uart_loader.sv | 117 +++++++++++
 tb/tb_imem_uart_loader.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_uart_loader_if.sv
// Byte stream from the UART receiver and the instruction-memory write port.
interface imem_uart_loader_if #(
    parameter int ADDR_W = 8
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_err;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output rx_valid, rx_data, rx_err,
        input  imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  rx_valid, rx_data, rx_err,
        output imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_uart_loader.sv
// UART boot loader: frames A5|LEN|payload|XOR into instruction memory,
// holding the core in reset until a checksum-verified image has landed.
module imem_uart_loader #(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    imem_uart_loader_if.slave bus,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int          TW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

    typedef enum logic [2:0] {
        IDLE, LEN0, LEN1, DATA, CHK, DONE, ERR
    } state_t;

    state_t        state, state_nxt;
    logic [15:0]   len;
    logic [15:0]   word_idx;
    logic [1:0]    byte_idx;
    logic [23:0]   shreg;
    logic [7:0]    csum;
    logic [TW-1:0] tmo_cnt;

    logic          byte_in;
    logic          is_sync;
    logic          tmo_hit;
    logic          abort;
    logic          last_byte;
    logic [15:0]   len_full;

    assign byte_in   = bus.rx_valid;
    assign is_sync   = byte_in && (bus.rx_data == 8'hA5);
    assign busy      = state inside {LEN0, LEN1, DATA, CHK};
    assign tmo_hit   = !byte_in && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
    assign abort     = busy && (bus.rx_err || tmo_hit);
    assign len_full  = {bus.rx_data, len[7:0]};
    assign last_byte = (byte_idx == 2'd3) && (word_idx == len - 16'd1);

    assign done      = (state == DONE);
    assign error     = (state == ERR);
    assign cpu_rst_n = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE, ERR: if (is_sync) state_nxt = LEN0;
            LEN0: if (byte_in) state_nxt = LEN1;
            LEN1: begin
                if (byte_in) begin
                    if (len_full == 16'd0)
                        state_nxt = CHK;
                    else if ({1'b0, len_full} > DEPTH)
                        state_nxt = ERR;
                    else
                        state_nxt = DATA;
                end
            end
            DATA: if (byte_in && last_byte) state_nxt = CHK;
            CHK: begin
                if (byte_in)
                    state_nxt = (bus.rx_data == csum) ? DONE : ERR;
            end
            default: state_nxt = IDLE;
        endcase
        // An abort discards whatever byte arrives alongside it.
        if (abort) state_nxt = ERR;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            len            <= '0;
            word_idx       <= '0;
            byte_idx       <= '0;
            shreg          <= '0;
            csum           <= '0;
            tmo_cnt        <= '0;
        end else begin
            bus.imem_we <= 1'b0;
            tmo_cnt     <= (byte_in || !busy) ? '0 : tmo_cnt + 1'b1;
            if (byte_in && !abort) begin
                if ((state inside {IDLE, DONE, ERR}) && is_sync) begin
                    csum     <= '0;
                    word_idx <= '0;
                    byte_idx <= '0;
                end
                if (state == LEN0) len[7:0]  <= bus.rx_data;
                if (state == LEN1) len[15:8] <= bus.rx_data;
                if (state == DATA) begin
                    csum     <= csum ^ bus.rx_data;
                    byte_idx <= byte_idx + 2'd1;
                    shreg    <= {bus.rx_data, shreg[23:8]};
                    // Little-endian: the fourth byte lands in bits 31:24.
                    if (byte_idx == 2'd3) begin
                        bus.imem_we    <= 1'b1;
                        bus.imem_addr  <= word_idx[ADDR_W-1:0];
                        bus.imem_wdata <= {bus.rx_data, shreg};
                        word_idx       <= word_idx + 16'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: expected-write queue built from the
// image words, checked every cycle, plus end-of-frame status checks.
module tb_imem_uart_loader;
    localparam int ADDR_W = 8;
    localparam int TMO    = 40;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
        int          due;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    logic cpu_rst_n, busy, done, error;
    int   edge_n = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    wr_t  expq[$];

    logic [31:0] t1[$];
    logic [31:0] big[$];
    logic [31:0] none[$];
    logic [7:0]  t2b[12];
    bit          t2w[12];

    imem_uart_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_uart_loader #(
        .ADDR_W(ADDR_W),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .cpu_rst_n(cpu_rst_n),
        .busy(busy),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] img_chk(input logic [31:0] w[$]);
        logic [31:0] x = '0;
        foreach (w[i]) x ^= w[i];
        return x[7:0] ^ x[15:8] ^ x[23:16] ^ x[31:24];
    endfunction

    // Every cycle: each imem_we must match the head of the expected queue
    always begin
        @(posedge clk);
        #1;
        if (bus.imem_we) begin
            n_assert++;
            if (expq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_we: addr %h data %h, none expected",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                wr_t e;
                e = expq.pop_front();
                chk("we_addr", 32'(bus.imem_addr), 32'(e.a));
                chk("we_data", bus.imem_wdata, e.d);
                chk("we_cycle", 32'(edge_n), 32'(e.due));
            end
        end else if (expq.size() > 0 && expq[0].due < edge_n) begin
            n_assert++;
            n_fail++;
            $display("FAIL missed_we: no write, expected addr %h data %h",
                     expq[0].a, expq[0].d);
            void'(expq.pop_front());
        end
        chk("cpu_rst_vs_done", 32'(cpu_rst_n), 32'(done));
    end

    task automatic put(input logic [7:0] b, input bit wr,
                       input logic [7:0] a, input logic [31:0] d,
                       input int gap);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk);
        if (wr) expq.push_back('{a: a, d: d, due: edge_n + 1});
        if (gap > 0) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_err   = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_load(input logic [31:0] w[$],
                             input logic [7:0] bad, input int gap);
        logic [15:0] n;
        n = 16'(w.size());
        put(8'hA5, 1'b0, 8'h0, 32'h0, gap);
        put(n[7:0], 1'b0, 8'h0, 32'h0, gap);
        put(n[15:8], 1'b0, 8'h0, 32'h0, gap);
        foreach (w[i])
            for (int b = 0; b < 4; b++)
                put(w[i][8*b +: 8], b == 3, 8'(i), w[i], gap);
        put(img_chk(w) ^ bad, 1'b0, 8'h0, 32'h0, gap);
        idle(3);
    endtask

    task automatic status(input string name, input bit d, input bit e);
        chk({name, "_done"}, 32'(done), 32'(d));
        chk({name, "_error"}, 32'(error), 32'(e));
        chk({name, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(d));
        chk({name, "_busy"}, 32'(busy), 32'h0);
        chk({name, "_pending"}, 32'(expq.size()), 32'h0);
    endtask

    task automatic all_zero(input string name);
        chk({name, "_done"}, 32'(done), 32'h0);
        chk({name, "_error"}, 32'(error), 32'h0);
        chk({name, "_busy"}, 32'(busy), 32'h0);
        chk({name, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'h0);
        chk({name, "_we"}, 32'(bus.imem_we), 32'h0);
        chk({name, "_addr"}, 32'(bus.imem_addr), 32'h0);
        chk({name, "_wdata"}, bus.imem_wdata, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_err   = 1'b0;
        t1  = '{32'h00000013, 32'h00100093};
        t2b = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00,
                8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h81};
        t2w = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
        for (int i = 0; i < 256; i++)
            big.push_back({8'(i), ~8'(i), 8'(i * 3), 8'hC3});

        repeat (3) @(negedge clk);
        all_zero("reset");
        rst_n = 1'b1;
        idle(2);
        all_zero("idle");

        chk("model_chk_t1", 32'(img_chk(t1)), 32'h90);
        chk("model_chk_empty", 32'(img_chk(none)), 32'h00);

        // Two-word image, spaced then back-to-back bytes
        send_load(t1, 8'h00, 1);
        status("t1", 1'b1, 1'b0);
        chk("t1_addr_hold", 32'(bus.imem_addr), 32'h1);
        chk("t1_data_hold", bus.imem_wdata, 32'h00100093);
        send_load(t1, 8'h00, 0);
        status("t1_b2b", 1'b1, 1'b0);

        // Bad checksum: words still written, core held
        for (int i = 0; i < 12; i++) begin
            put(t2b[i], t2w[i], (i == 6) ? 8'h0 : 8'h1,
                (i == 6) ? 32'h00000013 : 32'h00100093, 1);
            if (i == 0) begin
                chk("restart_busy", 32'(busy), 32'h1);
                chk("restart_done", 32'(done), 32'h0);
                chk("restart_cpu_rst_n", 32'(cpu_rst_n), 32'h0);
            end
        end
        idle(2);
        status("t2", 1'b0, 1'b1);

        // Garbage ignored, empty image
        put(8'h55, 1'b0, 8'h0, 32'h0, 1);
        put(8'h00, 1'b0, 8'h0, 32'h0, 1);
        chk("garbage_error", 32'(error), 32'h1);
        send_load(none, 8'h00, 1);
        status("t3", 1'b1, 1'b0);
        @(negedge clk) bus.rx_err = 1'b1;
        idle(2);
        status("rx_err_in_done", 1'b1, 1'b0);

        // Inter-byte timeout
        put(8'hA5, 1'b0, 8'h0, 32'h0, 1);
        put(8'h01, 1'b0, 8'h0, 32'h0, 1);
        put(8'h00, 1'b0, 8'h0, 32'h0, 1);
        put(8'h13, 1'b0, 8'h0, 32'h0, 1);
        put(8'h00, 1'b0, 8'h0, 32'h0, 1);
        idle(15);
        chk("tmo_still_busy", 32'(busy), 32'h1);
        chk("tmo_no_error_yet", 32'(error), 32'h0);
        idle(40);
        status("tmo", 1'b0, 1'b1);
        send_load(t1, 8'h00, 1);
        status("after_tmo", 1'b1, 1'b0);

        // Oversized length
        put(8'hA5, 1'b0, 8'h0, 32'h0, 1);
        put(8'h01, 1'b0, 8'h0, 32'h0, 1);
        put(8'h01, 1'b0, 8'h0, 32'h0, 1);
        status("len_257", 1'b0, 1'b1);

        // rx_err mid-DATA after one word
        put(8'hA5, 1'b0, 8'h0, 32'h0, 1);
        put(8'h02, 1'b0, 8'h0, 32'h0, 1);
        put(8'h00, 1'b0, 8'h0, 32'h0, 1);
        put(8'h13, 1'b0, 8'h0, 32'h0, 1);
        put(8'h00, 1'b0, 8'h0, 32'h0, 1);
        put(8'h00, 1'b0, 8'h0, 32'h0, 1);
        put(8'h00, 1'b1, 8'h0, 32'h00000013, 1);
        put(8'h93, 1'b0, 8'h0, 32'h0, 1);
        put(8'h00, 1'b0, 8'h0, 32'h0, 1);
        @(negedge clk) bus.rx_err = 1'b1;
        idle(2);
        status("rx_err_data", 1'b0, 1'b1);

        // rx_err together with a word-completing byte
        put(8'hA5, 1'b0, 8'h0, 32'h0, 1);
        put(8'h01, 1'b0, 8'h0, 32'h0, 1);
        put(8'h00, 1'b0, 8'h0, 32'h0, 1);
        put(8'h11, 1'b0, 8'h0, 32'h0, 1);
        put(8'h22, 1'b0, 8'h0, 32'h0, 1);
        put(8'h33, 1'b0, 8'h0, 32'h0, 1);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h44;
        bus.rx_err   = 1'b1;
        idle(2);
        status("abort_wins", 1'b0, 1'b1);
        chk("abort_data_hold", bus.imem_wdata, 32'h00000013);

        // Full-depth image
        send_load(big, 8'h00, 0);
        status("len_256", 1'b1, 1'b0);
        chk("len_256_last_addr", 32'(bus.imem_addr), 32'hFF);
        chk("len_256_last_data", bus.imem_wdata, 32'hFF00FDC3);

        // Reset mid-frame, landing on a word-completing byte
        put(8'hA5, 1'b0, 8'h0, 32'h0, 1);
        put(8'h02, 1'b0, 8'h0, 32'h0, 1);
        put(8'h00, 1'b0, 8'h0, 32'h0, 1);
        put(8'hEF, 1'b0, 8'h0, 32'h0, 1);
        put(8'hBE, 1'b0, 8'h0, 32'h0, 1);
        put(8'hAD, 1'b0, 8'h0, 32'h0, 1);
        put(8'hDE, 1'b1, 8'h0, 32'hDEADBEEF, 1);
        put(8'h01, 1'b0, 8'h0, 32'h0, 1);
        put(8'h02, 1'b0, 8'h0, 32'h0, 1);
        put(8'h03, 1'b0, 8'h0, 32'h0, 1);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h04;
        rst_n        = 1'b0;
        @(posedge clk);
        #1;
        all_zero("mid_reset");
        @(negedge clk);
        bus.rx_valid = 1'b0;
        rst_n        = 1'b1;
        send_load(t1, 8'h00, 1);
        status("after_reset", 1'b1, 1'b0);
        chk("after_reset_addr", 32'(bus.imem_addr), 32'h1);

        idle(3);
        chk("queue_drained", 32'(expq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
